// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared constants and state encoding for the binary-to-BCD converter
package bin_to_bcd_seq_pkg;

  localparam int          BCD_DIGITS = 4;
  localparam int          BCD_W      = 16;
  localparam logic [15:0] BCD_MAX    = 16'h9999;
  localparam int          CNT_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - add-3 correction for one BCD digit ahead of a double-dabble shift
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit of 5..9 would become >= 10 after doubling, so pre-add 3 to carry into the next digit
  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter, 14-bit binary to saturating 4-digit BCD
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd,
  output logic             overflow
);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;
  logic               unused_adj_msb;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // The fifth decimal digit falls off the top; values that need it are saturated instead
  assign unused_adj_msb = adj[BCD_W-1];
  assign shifted        = {adj[BCD_W-2:0], shift_q[BIN_W-1]};

  // Next-state: accept a request in IDLE, otherwise perform one adjust-and-shift step per clock
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d    = bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_W);
          ovf_flag_d = (int'(bin) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted;
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d      = ovf_flag_q ? BCD_MAX : shifted;
          overflow_d = ovf_flag_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = 14'd0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by plain arithmetic, saturating at 9999
  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Behavioural reference: a request is accepted when idle and its result appears 14 clocks later
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_bcd  = 16'h0;
  logic        m_ovf  = 1'b0;
  int          m_left = 0;
  int          m_val  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= 16'h0;
      m_ovf  <= 1'b0;
      m_left <= 0;
      m_val  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= 14;
          m_val  <= int'(bin);
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_bcd  <= to_bcd(m_val);
          m_ovf  <= (m_val > 9999);
        end
      end
    end
  end

  // Compare every output against the reference on each falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_bcd", 32'(bcd), 32'(m_bcd));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [13:0] v, input logic [15:0] eb, input logic eo, input string nm);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) bcnt++;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd14);
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'd14);
    check({nm, "_bcd"}, 32'(bcd), 32'(eb));
    check({nm, "_overflow"}, 32'(overflow), 32'(eo));
    check({nm, "_model_bcd"}, 32'(m_bcd), 32'(eb));
    for (int i = 0; i < 3; i++) tick();
    check({nm, "_bcd_hold"}, 32'(bcd), 32'(eb));
    check({nm, "_ovf_hold"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int dones;
    int gap;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset  = 1'b1;
    cmp_en = 1'b1;
    tick();

    run(14'd0, 16'h0000, 1'b0, "zero");
    run(14'd1234, 16'h1234, 1'b0, "v1234");
    run(14'd9999, 16'h9999, 1'b0, "v9999");
    run(14'd10000, 16'h9999, 1'b1, "v10000");
    run(14'd16383, 16'h9999, 1'b1, "v16383");
    run(14'd7, 16'h0007, 1'b0, "v7");

    // Second start during a conversion is ignored
    bin   = 14'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bin   = 14'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dones++;
    end
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_bcd", 32'(bcd), 32'h0042);

    // Start held high: back-to-back conversions
    bin   = 14'd5678;
    start = 1'b1;
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        gap = i;
        break;
      end
    end
    check("b2b_first_seen", 32'(gap != 0), 32'd1);
    check("b2b_bcd1", 32'(bcd), 32'h5678);
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        gap = i;
        break;
      end
    end
    check("b2b_gap1", 32'(gap), 32'd15);
    check("b2b_bcd2", 32'(bcd), 32'h5678);
    bin = 14'd90;
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        gap = i;
        break;
      end
    end
    start = 1'b0;
    check("b2b_gap2", 32'(gap), 32'd15);
    check("b2b_bcd3", 32'(bcd), 32'h0090);
    check("b2b_model_bcd3", 32'(m_bcd), 32'h0090);
    for (int i = 0; i < 18; i++) tick();
    check("b2b_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-conversion
    bin   = 14'd3000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("arst_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd", 32'(bcd), 32'h0);
    check("arst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    check("arst_bcd_after", 32'(bcd), 32'h0);

    run(14'd3000, 16'h3000, 1'b0, "v3000");

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
